// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture custom instruction: register select
// codes, command bits, channel FSM encoding and status word layout.
package pwm_capture_pkg;

  // valueA[1:0] register select for plain reads
  localparam logic [1:0] SEL_HI0  = 2'd0;
  localparam logic [1:0] SEL_PER0 = 2'd1;
  localparam logic [1:0] SEL_HI1  = 2'd2;
  localparam logic [1:0] SEL_PER1 = 2'd3;

  // valueA command bit positions
  localparam int unsigned CMD_STATUS = 2;
  localparam int unsigned CMD_CLEAR  = 3;

  // Per-channel measurement FSM
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  // Status word bit positions
  localparam int unsigned STAT_V0   = 0;
  localparam int unsigned STAT_V1   = 1;
  localparam int unsigned STAT_TO0  = 2;
  localparam int unsigned STAT_TO1  = 3;
  localparam int unsigned STAT_LVL0 = 4;
  localparam int unsigned STAT_LVL1 = 5;

endpackage

// File: rtl/pwm_capture_channel.sv
// One PWM measurement channel: synchronizer, edge detect, high-time/period
// counters with saturation timeout, and the latched result registers.
module pwm_capture_channel
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 21
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pwm,
  input  logic                 softClr,
  input  logic                 clrValid,
  input  logic                 clrTimeout,
  output logic [CNT_WIDTH-1:0] hiReg,
  output logic [CNT_WIDTH-1:0] perReg,
  output logic                 valid,
  output logic                 timeout,
  output logic                 level
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic [1:0]           warm;
  logic                 armed;
  logic                 rise;
  logic                 fall;
  logic                 at_max;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] hi_cnt;
  logic [CNT_WIDTH-1:0] per_cnt;
  logic [CNT_WIDTH-1:0] hi_tmp;

  // Edges are only trusted once sync and prev hold real samples; an input
  // already high at reset release must first go low before a rise counts.
  assign armed  = (warm == 2'd3);
  assign rise   = armed & sync2 & ~prev;
  assign fall   = armed & ~sync2 & prev;
  assign at_max = (per_cnt == '1);
  assign level  = sync2;

  // Two-flop synchronizer, previous-level flop and post-reset warm-up count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      warm  <= '0;
    end else begin
      sync1 <= pwm;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed) warm <= warm + 2'd1;
    end
  end

  // Measurement FSM; flag clears precede the case so a same-cycle latch or
  // saturation overrides them, and soft clear overrides everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hi_cnt  <= '0;
      per_cnt <= '0;
      hi_tmp  <= '0;
      hiReg   <= '0;
      perReg  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else if (softClr) begin
      state   <= IDLE;
      hi_cnt  <= '0;
      per_cnt <= '0;
      hi_tmp  <= '0;
      hiReg   <= '0;
      perReg  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (clrValid)   valid   <= 1'b0;
      if (clrTimeout) timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            hi_cnt  <= CNT_ONE;
            per_cnt <= CNT_ONE;
          end
        end
        HIGH: begin
          if (at_max) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            per_cnt <= per_cnt + CNT_ONE;
            if (fall) begin
              state  <= LOW;
              hi_tmp <= hi_cnt;
            end else begin
              hi_cnt <= hi_cnt + CNT_ONE;
            end
          end
        end
        LOW: begin
          if (rise) begin
            state   <= HIGH;
            hiReg   <= hi_tmp;
            perReg  <= per_cnt;
            valid   <= 1'b1;
            hi_cnt  <= CNT_ONE;
            per_cnt <= CNT_ONE;
          end else if (at_max) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            per_cnt <= per_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Two-channel pulse-width/period meter on the custom-instruction bus:
// instruction decode, read-clear strobes and the result multiplexer.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter logic [7:0]  customId  = 8'h00,
  parameter int unsigned CNT_WIDTH = 21
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [1:0]  pwmIn,
  output logic        done,
  output logic [31:0] result
);

  logic                 active;
  logic                 cmd_clear;
  logic                 cmd_status;
  logic                 cmd_read;
  logic                 clr_valid0;
  logic                 clr_valid1;
  logic [CNT_WIDTH-1:0] hi_reg0;
  logic [CNT_WIDTH-1:0] per_reg0;
  logic [CNT_WIDTH-1:0] hi_reg1;
  logic [CNT_WIDTH-1:0] per_reg1;
  logic                 valid0;
  logic                 valid1;
  logic                 timeout0;
  logic                 timeout1;
  logic                 level0;
  logic                 level1;
  logic                 unused_bits;

  assign unused_bits = ^{valueB, valueA[31:4]};

  assign active     = start && (ciN == customId);
  assign done       = active;
  assign cmd_clear  = active && valueA[CMD_CLEAR];
  assign cmd_status = active && !valueA[CMD_CLEAR] && valueA[CMD_STATUS];
  assign cmd_read   = active && !valueA[CMD_CLEAR] && !valueA[CMD_STATUS];
  assign clr_valid0 = cmd_read && (valueA[1:0] == SEL_PER0);
  assign clr_valid1 = cmd_read && (valueA[1:0] == SEL_PER1);

  pwm_capture_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch0 (
    .clock      (clock),
    .reset      (reset),
    .pwm        (pwmIn[0]),
    .softClr    (cmd_clear),
    .clrValid   (clr_valid0),
    .clrTimeout (cmd_status),
    .hiReg      (hi_reg0),
    .perReg     (per_reg0),
    .valid      (valid0),
    .timeout    (timeout0),
    .level      (level0)
  );

  pwm_capture_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch1 (
    .clock      (clock),
    .reset      (reset),
    .pwm        (pwmIn[1]),
    .softClr    (cmd_clear),
    .clrValid   (clr_valid1),
    .clrTimeout (cmd_status),
    .hiReg      (hi_reg1),
    .perReg     (per_reg1),
    .valid      (valid1),
    .timeout    (timeout1),
    .level      (level1)
  );

  // Read data: status word or zero-extended measurement, zero when idle or clearing
  always_comb begin
    result = '0;
    if (cmd_status) begin
      result[STAT_V0]   = valid0;
      result[STAT_V1]   = valid1;
      result[STAT_TO0]  = timeout0;
      result[STAT_TO1]  = timeout1;
      result[STAT_LVL0] = level0;
      result[STAT_LVL1] = level1;
    end else if (cmd_read) begin
      case (valueA[1:0])
        SEL_HI0:  result = 32'(hi_reg0);
        SEL_PER0: result = 32'(per_reg0);
        SEL_HI1:  result = 32'(hi_reg1);
        default:  result = 32'(per_reg1);
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: PWM stimulus on both channels with
// custom-instruction reads whose expected values go through a scoreboard queue.
module tb_pwm_capture;

  localparam logic [7:0]  ID = 8'h3C;
  localparam int unsigned CW = 12;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [7:0]  ciN    = '0;
  logic [31:0] valueA = '0;
  logic [31:0] valueB = '0;
  logic        pwm0   = 1'b0;
  logic        pwm1   = 1'b0;
  logic [1:0]  pwmIn;
  logic        done;
  logic [31:0] result;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  assign pwmIn = {pwm1, pwm0};

  pwm_capture #(.customId(ID), .CNT_WIDTH(CW)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .pwmIn  (pwmIn),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input int ch, input logic v);
    if (ch == 0) pwm0 = v;
    else         pwm1 = v;
  endtask

  task automatic burst(input int ch, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      drive(ch, 1'b1);
      tick(hi);
      drive(ch, 1'b0);
      tick(lo);
    end
  endtask

  // One custom instruction, issued at a falling edge and active over the next rising edge
  task automatic ci(input string tag, input logic [3:0] cmd, input logic [31:0] want);
    start  = 1'b1;
    ciN    = ID;
    valueA = ($urandom() & 32'hFFFF_FFF0) | {28'h0, cmd};
    valueB = $urandom();
    exp_q.push_back(want);
    #2;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check(tag, result, exp_q.pop_front());
    @(negedge clock);
    start  = 1'b0;
    valueA = '0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(5);
    ci("rst_hi0", 4'd0, 32'd0);
    ci("rst_per0", 4'd1, 32'd0);
    ci("rst_hi1", 4'd2, 32'd0);
    ci("rst_per1", 4'd3, 32'd0);
    ci("rst_status", 4'd4, 32'd0);

    // ch0 300 high / 700 low, three periods, reads interleaved
    fork
      burst(0, 300, 700, 3);
      begin
        tick(1005);
        ci("t1_status", 4'd4, 32'h11);
        ci("t1_hi0", 4'd0, 32'd300);
        ci("t1_per0", 4'd1, 32'd1000);
        ci("t2_status_cleared", 4'd4, 32'h10);
        tick(1001);
        ci("t2_status_relatched", 4'd4, 32'h11);
      end
    join
    // fourth rise after a longer low; read-clear lands on the latch edge
    tick(200);
    pwm0 = 1'b1;
    tick(2);
    ci("t2_per0_at_latch", 4'd1, 32'd1000);
    ci("t2_status_latch_wins", 4'd4, 32'h11);
    ci("t2_per0_new", 4'd1, 32'd1200);
    ci("t2_hi0_new", 4'd0, 32'd300);
    pwm0 = 1'b0;

    // ch1 single pulse then held low until the period counter saturates
    tick(5);
    ci("t3_clear", 4'd8, 32'd0);
    ci("t3_per0_cleared", 4'd1, 32'd0);
    pwm1 = 1'b1;
    tick(10);
    pwm1 = 1'b0;
    tick(4200);
    ci("t3_status_to1", 4'd4, 32'h08);
    ci("t3_status_to1_cleared", 4'd4, 32'h00);

    // ch0 1/1 toggling while ch1 runs 500/2500 independently
    fork
      burst(0, 1, 1, 20);
      burst(1, 500, 2500, 2);
      begin
        tick(60);
        ci("t4_status", 4'd4, 32'h21);
        ci("t4_hi0", 4'd0, 32'd1);
        ci("t4_per0", 4'd1, 32'd2);
        tick(2947);
        ci("t4_hi1", 4'd2, 32'd500);
        ci("t4_per1", 4'd3, 32'd3000);
        ci("t4_status2", 4'd4, 32'h20);
      end
    join

    // reset in the middle of a high phase
    pwm0 = 1'b1;
    tick(150);
    reset = 1'b0;
    tick(2);
    ci("t5_rst_hi0", 4'd0, 32'd0);
    ci("t5_rst_per0", 4'd1, 32'd0);
    ci("t5_rst_hi1", 4'd2, 32'd0);
    ci("t5_rst_per1", 4'd3, 32'd0);
    ci("t5_rst_status", 4'd4, 32'd0);
    reset = 1'b1;
    tick(143);
    pwm0 = 1'b0;
    tick(700);
    pwm0 = 1'b1;
    tick(10);
    ci("t5_status_fresh", 4'd4, 32'h10);
    tick(389);
    pwm0 = 1'b0;
    tick(600);
    pwm0 = 1'b1;
    tick(5);
    ci("t5_hi0", 4'd0, 32'd400);

    // foreign instruction number must neither answer nor clear
    start  = 1'b1;
    ciN    = ID ^ 8'h5A;
    valueA = 32'd1;
    #2;
    check("t6_foreign_done", {31'b0, done}, 32'd0);
    check("t6_foreign_result", result, 32'd0);
    @(negedge clock);
    start  = 1'b0;
    valueA = '0;
    ci("t6_status_kept", 4'd4, 32'h11);
    ci("t6_per0", 4'd1, 32'd1000);
    ci("t6_status_read_clr", 4'd4, 32'h10);
    ci("t6_clear", 4'd8, 32'd0);
    ci("t6_hi0_cleared", 4'd0, 32'd0);
    ci("t6_per0_cleared", 4'd1, 32'd0);
    ci("t6_status_cleared", 4'd4, 32'h10);
    pwm0 = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
